fir_xif_host: RTL and testbench

Core-side initiator for the eXtension Interface (XIF) used by the FIR coprocessor. It takes pre-decoded offload requests from an upstream instruction queue and drives the XIF issue handshake. After each issue it drives one commit transaction. It tracks writeback-expecting instructions in an ID scoreboard and returns coprocessor results as register-file write pulses. It sits in the core/subsystem wrapper and also serves as the stimulus engine for standalone coprocessor benches.

---
 rtl/fir_xif_host_if.sv | 36 +++
 rtl/fir_xif_host.sv | 201 ++++++++++++++++++++
 tb/tb_fir_xif_host.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_xif_host_if.sv
// XIF issue/commit/result bundle between the core-side host and the FIR coprocessor.
interface fir_xif_host_if #(parameter int ID_W = 4);
    logic             issue_valid_o;
    logic             issue_ready_i;
    logic [31:0]      issue_instr_o;
    logic [ID_W-1:0]  issue_id_o;
    logic [63:0]      issue_rs_o;
    logic [1:0]       issue_rs_valid_o;
    logic             issue_accept_i;
    logic             issue_writeback_i;
    logic             commit_valid_o;
    logic [ID_W-1:0]  commit_id_o;
    logic             commit_kill_o;
    logic             result_valid_i;
    logic             result_ready_o;
    logic [ID_W-1:0]  result_id_i;
    logic [31:0]      result_data_i;
    logic [4:0]       result_rd_i;
    logic             result_we_i;

    modport master (
        output issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
        input  issue_ready_i, issue_accept_i, issue_writeback_i,
        output commit_valid_o, commit_id_o, commit_kill_o,
        input  result_valid_i, result_id_i, result_data_i, result_rd_i, result_we_i,
        output result_ready_o
    );

    modport slave (
        input  issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
        output issue_ready_i, issue_accept_i, issue_writeback_i,
        input  commit_valid_o, commit_id_o, commit_kill_o,
        output result_valid_i, result_id_i, result_data_i, result_rd_i, result_we_i,
        input  result_ready_o
    );
endinterface

// File: rtl/fir_xif_host.sv
// Core-side XIF initiator: issue -> commit sequencing, writeback ID scoreboard, result writeback.
// Optional register hazard interlock on the scoreboard rd fields: FIR_XIF_HOST_HAZARD_EN.
module fir_xif_sb_entry #(
    parameter int ID_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alloc,
    input  logic            free,
    input  logic [ID_W-1:0] alloc_id,
    input  logic [4:0]      alloc_rd,
    output logic            valid,
    output logic [ID_W-1:0] id,
    output logic [4:0]      rd
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            id    <= '0;
            rd    <= '0;
        end else if (alloc) begin
            valid <= 1'b1;
            id    <= alloc_id;
            rd    <= alloc_rd;
        end else if (free) begin
            valid <= 1'b0;
        end
    end
endmodule

module fir_xif_host #(
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    fir_xif_host_if.master xif,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        illegal_o,
    output logic        err_o
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMMIT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] op_b;
        logic [31:0] op_a;
    } req_t;

    state_t                         state, state_d;
    req_t                           req_q;
    logic [ID_W-1:0]                id_cnt, commit_id_q;
    logic                           accept_q, wbk_q;

    logic [MAX_OUT-1:0]             sb_valid, sb_alloc, sb_free, sb_match;
    logic [MAX_OUT-1:0][ID_W-1:0]   sb_id;
    logic [MAX_OUT-1:0][4:0]        sb_rd;

    logic                           issue_hs, res_hs, want_alloc;
    logic                           found, placed, alloc_hit, res_hit, hazard;
    logic [CNT_W-1:0]               outstanding;

    genvar g;
    generate
        for (g = 0; g < MAX_OUT; g++) begin : g_sb
            fir_xif_sb_entry #(.ID_W(ID_W)) u_entry (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .alloc    (sb_alloc[g]),
                .free     (sb_free[g]),
                .alloc_id (commit_id_q),
                .alloc_rd (req_q.instr[11:7]),
                .valid    (sb_valid[g]),
                .id       (sb_id[g]),
                .rd       (sb_rd[g])
            );
        end
    endgenerate

    assign issue_hs   = (state == S_ISSUE) && xif.issue_ready_i;
    assign res_hs     = xif.result_valid_i && xif.result_ready_o;
    assign want_alloc = (state == S_COMMIT) && accept_q && wbk_q;

    // A result for the ID being committed this cycle cancels the allocation instead of freeing a slot.
    always_comb begin
        sb_free   = '0;
        sb_alloc  = '0;
        found     = 1'b0;
        placed    = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            sb_match[i] = sb_valid[i] && (sb_id[i] == xif.result_id_i);
            if (res_hs && sb_match[i] && !found) begin
                sb_free[i] = 1'b1;
                found      = 1'b1;
            end
        end
        alloc_hit = want_alloc && res_hs && !found && (xif.result_id_i == commit_id_q);
        res_hit   = found || alloc_hit;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (want_alloc && !alloc_hit && !sb_valid[i] && !placed) begin
                sb_alloc[i] = 1'b1;
                placed      = 1'b1;
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < MAX_OUT; i++)
            outstanding = outstanding + CNT_W'(sb_valid[i]);
    end

`ifdef FIR_XIF_HOST_HAZARD_EN
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (sb_valid[i] && (sb_rd[i] != 5'd0) &&
                ((sb_rd[i] == instr_i[19:15]) || (sb_rd[i] == instr_i[24:20]) ||
                 (sb_rd[i] == instr_i[11:7])))
                hazard = 1'b1;
        end
    end
`else
    logic sb_rd_unused;
    assign sb_rd_unused = ^sb_rd;
    assign hazard       = 1'b0;
`endif

    assign instr_ready_o = !rst_i && (state == S_IDLE) && (outstanding < MAX_CNT) && !hazard;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (instr_valid_i && instr_ready_o) state_d = S_ISSUE;
            S_ISSUE:  if (xif.issue_ready_i) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q       <= '0;
            id_cnt      <= '0;
            commit_id_q <= '0;
            accept_q    <= 1'b0;
            wbk_q       <= 1'b0;
        end else begin
            if (state == S_IDLE && instr_valid_i && instr_ready_o)
                req_q <= '{instr: instr_i, op_b: op_b_i, op_a: op_a_i};
            if (issue_hs) begin
                accept_q    <= xif.issue_accept_i;
                wbk_q       <= xif.issue_writeback_i;
                commit_id_q <= id_cnt;
                id_cnt      <= id_cnt + 1'b1;
            end
        end
    end

    // Writes to x0 still pulse but always carry zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            wb_valid_o <= res_hs && res_hit && xif.result_we_i;
            wb_rd_o    <= (res_hs && res_hit && xif.result_we_i) ? xif.result_rd_i : 5'd0;
            wb_data_o  <= (res_hs && res_hit && xif.result_we_i && xif.result_rd_i != 5'd0)
                          ? xif.result_data_i : 32'd0;
            err_o      <= res_hs && !res_hit;
        end
    end

    assign xif.issue_valid_o    = (state == S_ISSUE);
    assign xif.issue_rs_valid_o = {2{state == S_ISSUE}};
    assign xif.issue_instr_o    = req_q.instr;
    assign xif.issue_rs_o       = {req_q.op_b, req_q.op_a};
    assign xif.issue_id_o       = id_cnt;
    assign xif.commit_valid_o   = (state == S_COMMIT);
    assign xif.commit_id_o      = commit_id_q;
    assign xif.commit_kill_o    = (state == S_COMMIT) && !accept_q;
    assign xif.result_ready_o   = !rst_i;
    assign illegal_o            = (state == S_COMMIT) && !accept_q;
endmodule

// File: tb/tb_fir_xif_host.sv
// Directed bench for fir_xif_host (ID_W=2, MAX_OUT=3): issue, backpressure, reject, full/wrap, stray, hazard, reset.
module tb_fir_xif_host;
    localparam int ID_W    = 2;
    localparam int MAX_OUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, op_a, op_b;
    logic        wb_valid, illegal, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          n_chk = 0;
    int          n_err = 0;

    fir_xif_host_if #(.ID_W(ID_W)) xif ();

    fir_xif_host #(.ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr_valid_i(instr_valid),
        .instr_ready_o(instr_ready),
        .instr_i      (instr),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .xif          (xif),
        .wb_valid_o   (wb_valid),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .illegal_o    (illegal),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for ready, return one cycle after acceptance (in ISSUE).
    task automatic req(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        instr_valid = 1'b1; instr = ins; op_a = a; op_b = b;
        #1;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0; instr = '0; op_a = '0; op_b = '0;
    endtask

    task automatic result(input logic [ID_W-1:0] id, input logic [4:0] rd,
                          input logic [31:0] data, input logic we);
        xif.result_valid_i = 1'b1;
        xif.result_id_i    = id;
        xif.result_rd_i    = rd;
        xif.result_data_i  = data;
        xif.result_we_i    = we;
        tick();
        xif.result_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; op_a = '0; op_b = '0;
        xif.issue_ready_i = 1'b0; xif.issue_accept_i = 1'b0; xif.issue_writeback_i = 1'b0;
        xif.result_valid_i = 1'b0; xif.result_id_i = '0; xif.result_data_i = '0;
        xif.result_rd_i = '0; xif.result_we_i = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_res_ready", xif.result_ready_o, 0);
        chk("rst_instr_ready", instr_ready, 0);
        chk("rst_issue_valid", xif.issue_valid_o, 0);
        chk("rst_commit_valid", xif.commit_valid_o, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;
        chk("res_ready", xif.result_ready_o, 1);
        chk("idle_ready", instr_ready, 1);

        // single op
        xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b1; xif.issue_writeback_i = 1'b1;
        req(32'h0000_208B, 32'd5, 32'd7);
        chk("one_issue_valid", xif.issue_valid_o, 1);
        chk("one_issue_id", xif.issue_id_o, 0);
        chk("one_issue_instr", xif.issue_instr_o, 32'h0000_208B);
        chk("one_issue_rs", xif.issue_rs_o, 64'h0000_0007_0000_0005);
        chk("one_rs_valid", xif.issue_rs_valid_o, 2'b11);
        chk("one_busy_ready", instr_ready, 0);
        tick();
        chk("one_commit_valid", xif.commit_valid_o, 1);
        chk("one_commit_id", xif.commit_id_o, 0);
        chk("one_commit_kill", xif.commit_kill_o, 0);
        chk("one_illegal", illegal, 0);
        chk("one_issue_drop", xif.issue_valid_o, 0);
        tick();
        chk("one_commit_end", xif.commit_valid_o, 0);
        chk("one_next_ready", instr_ready, 1);
        result(2'd0, 5'd1, 32'h23, 1'b1);
        chk("one_wb_valid", wb_valid, 1);
        chk("one_wb_rd", wb_rd, 1);
        chk("one_wb_data", wb_data, 32'h23);
        chk("one_err", err, 0);
        tick();
        chk("one_wb_pulse", wb_valid, 0);

        // backpressure
        xif.issue_ready_i = 1'b0; xif.issue_writeback_i = 1'b0;
        req(32'h00A0_0113, 32'h11, 32'h22);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", xif.issue_valid_o, 1);
            chk("bp_instr", xif.issue_instr_o, 32'h00A0_0113);
            chk("bp_rs", xif.issue_rs_o, 64'h0000_0022_0000_0011);
            chk("bp_no_commit", xif.commit_valid_o, 0);
            tick();
        end
        chk("bp_id", xif.issue_id_o, 1);
        xif.issue_ready_i = 1'b1;
        tick();
        chk("bp_commit", xif.commit_valid_o, 1);
        chk("bp_commit_id", xif.commit_id_o, 1);
        tick();
        chk("bp_commit_end", xif.commit_valid_o, 0);

        // reject
        xif.issue_accept_i = 1'b0; xif.issue_writeback_i = 1'b1;
        req(32'h0000_030B, 32'd1, 32'd2);
        chk("rej_id", xif.issue_id_o, 2);
        tick();
        chk("rej_commit", xif.commit_valid_o, 1);
        chk("rej_commit_id", xif.commit_id_o, 2);
        chk("rej_kill", xif.commit_kill_o, 1);
        chk("rej_illegal", illegal, 1);
        tick();
        chk("rej_illegal_pulse", illegal, 0);
        result(2'd2, 5'd6, 32'h99, 1'b1);
        chk("rej_not_pending_err", err, 1);
        chk("rej_no_wb", wb_valid, 0);
        tick();

        // stray result
        result(2'd3, 5'd9, 32'h44, 1'b1);
        chk("stray_err", err, 1);
        chk("stray_no_wb", wb_valid, 0);
        tick();
        chk("stray_err_pulse", err, 0);

        // fill the scoreboard: ids 3,0,1 with rd 2,3,5
        xif.issue_accept_i = 1'b1; xif.issue_writeback_i = 1'b1;
        req(32'h0000_010B, 32'd0, 32'd0);
        chk("full_id0", xif.issue_id_o, 3);
        tick(); tick();
        req(32'h0000_018B, 32'd0, 32'd0);
        chk("full_id1", xif.issue_id_o, 0);
        tick(); tick();
        req(32'h0000_028B, 32'd0, 32'd0);
        chk("full_id2", xif.issue_id_o, 1);
        tick(); tick();
        chk("full_ready", instr_ready, 0);
        result(2'd0, 5'd3, 32'h55, 1'b1);
        chk("full_wb_valid", wb_valid, 1);
        chk("full_wb_rd", wb_rd, 3);
        chk("full_wb_data", wb_data, 32'h55);
        chk("full_ready_back", instr_ready, 1);
        tick();
        result(2'd3, 5'd2, 32'h66, 1'b0);
        chk("nowe_wb", wb_valid, 0);
        chk("nowe_err", err, 0);
        tick();

        // hazard: pending rd=4 (id 2), then an instr reading x4
        req(32'h0000_020B, 32'd0, 32'd0);
        chk("hz_id", xif.issue_id_o, 2);
        tick(); tick();
        xif.issue_ready_i = 1'b0;
        instr_valid = 1'b1; instr = 32'h0002_030B;
        #1;
`ifdef FIR_XIF_HOST_HAZARD_EN
        chk("hz_stall", instr_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hz_stall_hold", instr_ready, 0);
            chk("hz_no_issue", xif.issue_valid_o, 0);
        end
        result(2'd2, 5'd4, 32'h77, 1'b1);
        chk("hz_wb", wb_valid, 1);
        chk("hz_release", instr_ready, 1);
`else
        chk("hz_off_ready", instr_ready, 1);
`endif
        tick();
        instr_valid = 1'b0; instr = '0;
        chk("hz_issue", xif.issue_valid_o, 1);
        chk("hz_issue_id", xif.issue_id_o, 3);

        // reset while stuck in ISSUE
        tick();
        chk("mid_issue_hold", xif.issue_valid_o, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", xif.issue_valid_o, 0);
        chk("mid_rst_id", xif.issue_id_o, 0);
        chk("mid_rst_res_ready", xif.result_ready_o, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", instr_ready, 1);
        chk("mid_rst_commit", xif.commit_valid_o, 0);

        // ID wrap over 8 non-writeback ops
        xif.issue_ready_i = 1'b1; xif.issue_accept_i = 1'b1; xif.issue_writeback_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req(32'h0000_008B, i, i);
            chk("wrap_issue_id", xif.issue_id_o, i % 4);
            tick();
            chk("wrap_commit_id", xif.commit_id_o, i % 4);
            tick();
        end

        // result in the commit cycle of its own op, rd=x0 forces zero data
        xif.issue_writeback_i = 1'b1;
        req(32'h0000_000B, 32'd0, 32'd0);
        chk("same_id", xif.issue_id_o, 0);
        tick();
        chk("same_commit", xif.commit_valid_o, 1);
        result(2'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        chk("same_wb_valid", wb_valid, 1);
        chk("same_wb_rd", wb_rd, 0);
        chk("same_wb_data", wb_data, 0);
        chk("same_err", err, 0);
        tick();
        result(2'd0, 5'd0, 32'h1, 1'b1);
        chk("same_entry_gone", err, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
